// File: rtl/nios2_oci_trace_pkg.sv
// Shared definitions for the Nios II on-chip trace direct-branch packer.
// Holds the branch-outcome code values, the default frame depth and the
// output-slot state encoding used by the packer and its testbench.
package nios2_oci_trace_pkg;

   // Default number of codes per frame and bits per code.
   localparam int DCT_FRAMES_DEFAULT = 15;
   localparam int CODE_W_DEFAULT     = 2;

   // Branch-outcome codes. 2'b00 never appears, so an all-zero field always
   // marks an unused slot in a partial frame.
   localparam logic [1:0] CODE_TAKEN     = 2'b10;
   localparam logic [1:0] CODE_NOT_TAKEN = 2'b01;

   // Output-slot state:
   //   SLOT_EMPTY   - output register holds no frame
   //   SLOT_PENDING - output register holds a frame awaiting frame_ready
   //   SLOT_STALL   - output register occupied and the accumulator also holds
   //                  a closed frame waiting to move into it
   typedef enum logic [1:0] {
      SLOT_EMPTY   = 2'd0,
      SLOT_PENDING = 2'd1,
      SLOT_STALL   = 2'd2
   } slot_state_e;

   function automatic logic [1:0] encode_dct(input logic taken);
      return taken ? CODE_TAKEN : CODE_NOT_TAKEN;
   endfunction

endpackage

// File: rtl/de2i_150_qsys_nios2_cpu_oci_dct_packer_if.sv
// Frame handshake bundle between the frame producer and its consumer.
//   frame_valid - a frame is presented on dct_buffer/dct_count
//   frame_ready - consumer accepts the frame this cycle
//   dct_buffer  - packed codes, newest in the low CODE_W bits
//   dct_count   - number of valid codes in dct_buffer
// master: the side that presents frames; slave: the side that accepts them.
interface de2i_150_qsys_nios2_cpu_oci_dct_packer_if #(
   parameter int DCT_FRAMES = 15,
   parameter int CODE_W     = 2
);
   localparam int BUF_W = DCT_FRAMES * CODE_W;
   localparam int CNT_W = $clog2(DCT_FRAMES + 1);

   logic             frame_valid;
   logic             frame_ready;
   logic [BUF_W-1:0] dct_buffer;
   logic [CNT_W-1:0] dct_count;

   modport master (
      output frame_valid,
      output dct_buffer,
      output dct_count,
      input  frame_ready
   );

   modport slave (
      input  frame_valid,
      input  dct_buffer,
      input  dct_count,
      output frame_ready
   );
endinterface

// File: rtl/de2i_150_qsys_nios2_cpu_oci_dct_frame_reg.sv
// Output frame register with valid/ready handshake.
//   clk, reset  - clock and synchronous active-high reset
//   load        - capture load_buffer/load_count and present them next cycle
//   load_buffer - frame contents to capture
//   load_count  - number of codes in the frame to capture
//   handshake   - frame_valid && frame_ready this cycle
//   out         - frame bundle presented to the consumer
// The captured frame stays stable until the consumer takes it; a load in
// the same cycle as a handshake replaces it without a bubble.
module de2i_150_qsys_nios2_cpu_oci_dct_frame_reg #(
   parameter  int DCT_FRAMES = 15,
   parameter  int CODE_W     = 2,
   localparam int BUF_W      = DCT_FRAMES * CODE_W,
   localparam int CNT_W      = $clog2(DCT_FRAMES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BUF_W-1:0] load_buffer,
   input  logic [CNT_W-1:0] load_count,
   output logic             handshake,
   de2i_150_qsys_nios2_cpu_oci_dct_packer_if.master out
);

   logic             valid_q,  valid_d;
   logic [BUF_W-1:0] buffer_q, buffer_d;
   logic [CNT_W-1:0] count_q,  count_d;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and a latch is never inferred.
      handshake = valid_q && out.frame_ready;
      valid_d   = valid_q;
      buffer_d  = buffer_q;
      count_d   = count_q;
      if (load) begin
         valid_d  = 1'b1;
         buffer_d = load_buffer;
         count_d  = load_count;
      end else if (handshake) begin
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples values from before this edge, independent of statement order.
      if (reset) begin
         valid_q  <= 1'b0;
         buffer_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         buffer_q <= buffer_d;
         count_q  <= count_d;
      end
   end

   assign out.frame_valid = valid_q;
   assign out.dct_buffer  = buffer_q;
   assign out.dct_count   = count_q;

endmodule

// File: rtl/de2i_150_qsys_nios2_cpu_oci_dct_packer.sv
// Direct-branch trace packer.
//   clk, reset  - clock and synchronous active-high reset
//   trc_on      - trace enable; branch events are ignored while low
//   dct_valid   - one direct-branch event this cycle
//   dct_taken   - outcome of that branch
//   flush_req   - close the partial frame (indirect branch / exception)
//   frame_ready - downstream accepts the presented frame
//   frame_valid - dct_buffer/dct_count hold a frame
//   dct_buffer  - packed codes, newest in bits [1:0], unused upper bits zero
//   dct_count   - number of valid codes in dct_buffer
//   overflow    - sticky: an event was dropped because no space was left
// Branch outcomes are shifted into an accumulator; a full or flushed
// accumulator closes a frame, which moves into the output register as soon
// as that register is free.
module de2i_150_qsys_nios2_cpu_oci_dct_packer
   import nios2_oci_trace_pkg::*;
#(
   parameter  int DCT_FRAMES = DCT_FRAMES_DEFAULT,
   parameter  int CODE_W     = CODE_W_DEFAULT,
   localparam int BUF_W      = DCT_FRAMES * CODE_W,
   localparam int CNT_W      = $clog2(DCT_FRAMES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trc_on,
   input  logic             dct_valid,
   input  logic             dct_taken,
   input  logic             flush_req,
   input  logic             frame_ready,
   output logic             frame_valid,
   output logic [BUF_W-1:0] dct_buffer,
   output logic [CNT_W-1:0] dct_count,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DCT_FRAMES);

   de2i_150_qsys_nios2_cpu_oci_dct_packer_if #(
      .DCT_FRAMES (DCT_FRAMES),
      .CODE_W     (CODE_W)
   ) frm ();

   assign frm.frame_ready = frame_ready;
   assign frame_valid     = frm.frame_valid;
   assign dct_buffer      = frm.dct_buffer;
   assign dct_count       = frm.dct_count;

   slot_state_e      state_q, state_d;
   logic [BUF_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             overflow_q, overflow_d;

   logic              event_in;
   logic [CODE_W-1:0] code;
   logic [BUF_W-1:0]  post_acc;
   logic [CNT_W-1:0]  post_cnt;
   logic              acc_full;
   logic              can_xfer;
   logic              close;
   logic              load;
   logic [BUF_W-1:0]  load_buffer;
   logic [CNT_W-1:0]  load_count;
   logic              handshake;
   logic              held_closed;

   // ---------------- accumulator and transfer datapath ----------------
   always_comb begin
      event_in    = dct_valid && trc_on;
      code        = CODE_W'(encode_dct(dct_taken));
      acc_full    = (acc_cnt_q == FULL_CNT);
      can_xfer    = !frm.frame_valid || frame_ready;
      post_acc    = event_in ? {acc_q[BUF_W-CODE_W-1:0], code} : acc_q;
      post_cnt    = acc_cnt_q + CNT_W'(event_in);
      close       = 1'b0;
      load        = 1'b0;
      load_buffer = acc_q;
      load_count  = acc_cnt_q;
      acc_d       = acc_q;
      acc_cnt_d   = acc_cnt_q;
      overflow_d  = overflow_q;

      if (acc_full) begin
         // A full accumulator is always a closed frame. It can only drain
         // into the output register; a new event either starts the next
         // frame (if the drain happens now) or is lost.
         close = 1'b1;
         if (can_xfer) begin
            load      = 1'b1;
            acc_d     = event_in ? BUF_W'(code) : '0;
            acc_cnt_d = CNT_W'(event_in);
         end else if (event_in) begin
            overflow_d = 1'b1;
         end
      end else begin
         // The event is appended first, so a same-cycle flush includes it.
         // A frame already closed but stalled keeps absorbing events.
         close = held_closed || (post_cnt == FULL_CNT) ||
                 (flush_req && (post_cnt != '0));
         if (close && can_xfer) begin
            load        = 1'b1;
            load_buffer = post_acc;
            load_count  = post_cnt;
            acc_d       = '0;
            acc_cnt_d   = '0;
         end else begin
            acc_d       = post_acc;
            acc_cnt_d   = post_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q      <= '0;
         acc_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         acc_cnt_q  <= acc_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;

   // ---------------- output-slot FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= SLOT_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SLOT_EMPTY:   if (close) state_d = SLOT_PENDING;
         SLOT_PENDING: begin
            if (handshake) state_d = close ? SLOT_PENDING : SLOT_EMPTY;
            else if (close) state_d = SLOT_STALL;
         end
         SLOT_STALL:   if (handshake) state_d = SLOT_PENDING;
         default:      state_d = SLOT_EMPTY;
      endcase
   end

   always_comb begin
      held_closed = (state_q == SLOT_STALL);
   end

   // ---------------- output register ----------------
   de2i_150_qsys_nios2_cpu_oci_dct_frame_reg #(
      .DCT_FRAMES (DCT_FRAMES),
      .CODE_W     (CODE_W)
   ) u_frame_reg (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_buffer (load_buffer),
      .load_count  (load_count),
      .handshake   (handshake),
      .out         (frm.master)
   );

endmodule
